comparator_serial_16: RTL

COMPARATOR_SERIAL_16 -- requirements
Module: comparator_serial_16

---
 rtl/comparator_pkg.sv | 33 +++
 rtl/nibble_cmp.sv | 14 +
 rtl/comparator_serial_16.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// Shared types and constants for the serial 16-bit magnitude comparator.
// COMPARATOR_SIGNED_EN selects two's-complement operand capture.
package comparator_pkg;

    localparam int NIBBLES = 4;
    localparam int NIB_W   = 4;
    localparam int DATA_W  = NIBBLES * NIB_W;
    localparam int IDX_W   = 2;
    localparam int CYC_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic great;
        logic equal;
        logic less;
    } result_t;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the nibble scan itself never needs to know about signedness.
    function automatic logic [DATA_W-1:0] capture_operand(input logic [DATA_W-1:0] v);
`ifdef COMPARATOR_SIGNED_EN
        return {~v[DATA_W-1], v[DATA_W-2:0]};
`else
        return v;
`endif
    endfunction

endpackage

// File: rtl/nibble_cmp.sv
// Combinational 4-bit unsigned greater-than / less-than compare.
module nibble_cmp
    import comparator_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o
);

    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/comparator_serial_16.sv
// Serial 16-bit comparator scanning one nibble per cycle, MSB nibble first.
// Define COMPARATOR_SIGNED_EN for two's-complement comparison.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// CMP   | comparing nibble idx_q, descending from 3 to 0
// DONE  | result held with out_valid=1 until out_ready
module comparator_serial_16
    import comparator_pkg::*;
#(
    parameter int EARLY_EXIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              greatin,
    input  logic              equalin,
    input  logic              lessin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              great,
    output logic              equal,
    output logic              less,
    output logic [CYC_W-1:0]  cycles
);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    result_t            casc_q, casc_d;
    result_t            res_q, res_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               decided_q, decided_d;

    logic [NIB_W-1:0]   nib_a, nib_b;
    logic               nib_gt, nib_lt;
    logic               nib_diff;
    logic               last_nib;

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        case (idx_q)
            2'd3: begin nib_a = a_q[15:12]; nib_b = b_q[15:12]; end
            2'd2: begin nib_a = a_q[11:8];  nib_b = b_q[11:8];  end
            2'd1: begin nib_a = a_q[7:4];   nib_b = b_q[7:4];   end
            default: begin nib_a = a_q[3:0]; nib_b = b_q[3:0];  end
        endcase
    end

    nibble_cmp u_nibble_cmp (
        .a_i  (nib_a),
        .b_i  (nib_b),
        .gt_o (nib_gt),
        .lt_o (nib_lt)
    );

    assign nib_diff = nib_gt | nib_lt;
    assign last_nib = (idx_q == '0);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        casc_d    = casc_q;
        res_d     = res_q;
        idx_d     = idx_q;
        cyc_d     = cyc_q;
        decided_d = decided_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d       = capture_operand(a);
                    b_d       = capture_operand(b);
                    casc_d    = '{great: greatin, equal: equalin, less: lessin};
                    res_d     = '0;
                    idx_d     = IDX_W'(NIBBLES - 1);
                    cyc_d     = '0;
                    decided_d = 1'b0;
                    state_d   = CMP;
                end
            end

            CMP: begin
                cyc_d = cyc_q + 3'd1;
                // Only the first difference counts; later nibbles are ignored.
                if (!decided_q && nib_diff) begin
                    res_d     = '{great: nib_gt, equal: 1'b0, less: nib_lt};
                    decided_d = 1'b1;
                end
                if (last_nib && !decided_q && !nib_diff) begin
                    res_d = casc_q;
                end
                if ((EARLY_EXIT != 0 && !decided_q && nib_diff) || last_nib) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 2'd1;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            casc_q    <= '0;
            res_q     <= '0;
            idx_q     <= '0;
            cyc_q     <= '0;
            decided_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            casc_q    <= casc_d;
            res_q     <= res_d;
            idx_q     <= idx_d;
            cyc_q     <= cyc_d;
            decided_q <= decided_d;
        end
    end

    assign great  = res_q.great;
    assign equal  = res_q.equal;
    assign less   = res_q.less;
    assign cycles = cyc_q;

endmodule
